fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of `decode_stage`. Owns the PC, issues requests to a variable-latency instruction memory over a req/ack handshake, and drives the fetch/decode pipeline register (`instr_d`, `pc_d`, `pc_plus4_d`) that decode consumes. Handles hazard-unit stalls, execute-stage branch/jump redirects, and squashing of in-flight fetches. Inserts NOP bubbles whenever no instruction is available.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_buffer.sv | 39 +++
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 tb/tb_fetch_stage.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: data width, bubble encoding and the
// fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        KILL = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for an instruction returned while the pipeline
// is stalled; load wins over drop when both are requested.
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            srst,
    input  logic            i_load,
    input  logic            i_drop,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc
);

    logic            r_valid;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, runs a single-outstanding req/ack
// fetch to instruction memory and drives the fetch/decode pipeline register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc_f;
    logic [XLEN-1:0] w_pc_f_next;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] w_req_addr_next;

    logic [XLEN-1:0] r_instr_d;
    logic [XLEN-1:0] r_pc_d;
    logic [XLEN-1:0] r_pc_plus4_d;
    logic [XLEN-1:0] w_instr_d_next;
    logic [XLEN-1:0] w_pc_d_next;
    logic [XLEN-1:0] w_pc_plus4_d_next;

    logic            w_hold;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_req_plus4;
    logic            w_buf_load;
    logic            w_buf_drop;
    logic            w_buf_valid;
    logic [XLEN-1:0] w_buf_instr;
    logic [XLEN-1:0] w_buf_pc;
    logic [XLEN-1:0] w_buf_pc_plus4;

    assign w_hold         = stall_f | stall_d;
    assign w_target       = align_word(pc_target_e);
    assign w_req_plus4    = r_req_addr + PC_STEP;
    assign w_buf_pc_plus4 = w_buf_pc + PC_STEP;

    // The reset is asynchronous, so the request is gated directly by srst.
    assign imem_req   = ~srst & (r_state != HOLD);
    assign imem_addr  = r_req_addr;
    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc_plus4_d = r_pc_plus4_d;

    fetch_buffer u_fetch_buffer (
        .clk     (clk),
        .srst    (srst),
        .i_load  (w_buf_load),
        .i_drop  (w_buf_drop),
        .i_instr (imem_rdata),
        .i_pc    (r_req_addr),
        .o_valid (w_buf_valid),
        .o_instr (w_buf_instr),
        .o_pc    (w_buf_pc)
    );

    always_comb begin
        w_state_next      = r_state;
        w_pc_f_next       = r_pc_f;
        w_req_addr_next   = r_req_addr;
        w_buf_load        = 1'b0;
        w_buf_drop        = 1'b0;
        w_instr_d_next    = r_instr_d;
        w_pc_d_next       = r_pc_d;
        w_pc_plus4_d_next = r_pc_plus4_d;

        case (r_state)
            WAIT: begin
                if (pc_src_e) begin
                    w_pc_f_next = w_target;
                    if (imem_ack) begin
                        w_req_addr_next = w_target;
                    end else begin
                        w_state_next = KILL;
                    end
                end else if (imem_ack) begin
                    w_pc_f_next = w_req_plus4;
                    if (w_hold) begin
                        w_buf_load   = 1'b1;
                        w_state_next = HOLD;
                    end else begin
                        w_req_addr_next   = w_req_plus4;
                        w_instr_d_next    = imem_rdata;
                        w_pc_d_next       = r_req_addr;
                        w_pc_plus4_d_next = w_req_plus4;
                    end
                end else if (!w_hold) begin
                    w_instr_d_next    = NOP_INSTR;
                    w_pc_d_next       = '0;
                    w_pc_plus4_d_next = '0;
                end
            end
            HOLD: begin
                if (pc_src_e) begin
                    w_pc_f_next     = w_target;
                    w_req_addr_next = w_target;
                    w_buf_drop      = 1'b1;
                    w_state_next    = WAIT;
                end else if (!w_hold) begin
                    w_req_addr_next = r_pc_f;
                    w_buf_drop      = 1'b1;
                    w_state_next    = WAIT;
                    if (w_buf_valid) begin
                        w_instr_d_next    = w_buf_instr;
                        w_pc_d_next       = w_buf_pc;
                        w_pc_plus4_d_next = w_buf_pc_plus4;
                    end else begin
                        w_instr_d_next    = NOP_INSTR;
                        w_pc_d_next       = '0;
                        w_pc_plus4_d_next = '0;
                    end
                end
            end
            KILL: begin
                // The address of the squashed request stays on the bus until it is acked.
                if (pc_src_e) begin
                    w_pc_f_next = w_target;
                    if (imem_ack) begin
                        w_req_addr_next = w_target;
                        w_state_next    = WAIT;
                    end
                end else begin
                    if (imem_ack) begin
                        w_req_addr_next = r_pc_f;
                        w_state_next    = WAIT;
                    end
                    if (!w_hold) begin
                        w_instr_d_next    = NOP_INSTR;
                        w_pc_d_next       = '0;
                        w_pc_plus4_d_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = WAIT;
            end
        endcase

        if (pc_src_e || flush_d) begin
            w_instr_d_next    = NOP_INSTR;
            w_pc_d_next       = '0;
            w_pc_plus4_d_next = '0;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_state      <= WAIT;
            r_pc_f       <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc_f       <= w_pc_f_next;
            r_req_addr   <= w_req_addr_next;
            r_instr_d    <= w_instr_d_next;
            r_pc_d       <= w_pc_d_next;
            r_pc_plus4_d <= w_pc_plus4_d_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a variable-latency memory responder, a scoreboard of
// expected decode-stage instructions and one task per scenario.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        stall_f = 1'b0;
    logic        stall_d = 1'b0;
    logic        flush_d = 1'b0;
    logic        pc_src_e = 1'b0;
    logic [31:0] pc_target_e = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          lat = 0;
    logic        mem_en = 1'b0;
    int          wait_cnt;
    logic        mon_h;
    logic [31:0] mon_e;

    fetch_stage dut (
        .clk         (clk),
        .srst        (srst),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h8000_0033 ^ a;
    endfunction

    // Memory: acks once a request has waited 'lat' cycles (lat=0 is zero-wait).
    always_comb begin
        imem_ack   = imem_req && mem_en && (wait_cnt >= lat);
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    always @(posedge clk or posedge srst) begin
        if (srst)                       wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    // Scoreboard consumer: a non-bubble decode value after an unstalled edge is a new instruction.
    always @(posedge clk) begin
        mon_h = stall_f | stall_d | srst;
        #1;
        if (!srst && !mon_h && instr_d !== NOP) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got instr_d=%h pc_d=%h, required no instruction", instr_d, pc_d);
            end else begin
                mon_e = exp_q.pop_front();
                if (instr_d !== mem_word(mon_e) || pc_d !== mon_e || pc_plus4_d !== mon_e + 32'd4) begin
                    n_fail++;
                    $display("FAIL sb_instr: got instr_d=%h pc_d=%h pc_plus4_d=%h, required %h %h %h",
                             instr_d, pc_d, pc_plus4_d, mem_word(mon_e), mon_e, mon_e + 32'd4);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = '0;
        srst = 1;
        step();
        step();
        srst = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        mem_en = 0; lat = 0;
        srst = 1;
        step();
        step();
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_req: got %b, required 0", imem_req);
        end
        n_checks++;
        if (instr_d !== NOP || pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin
            n_fail++; $display("FAIL rst_decode: got %h %h %h, required %h 0 0", instr_d, pc_d, pc_plus4_d, NOP);
        end
        srst = 0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_release: got req=%b addr=%h, required 1 0", imem_req, imem_addr);
        end
        step();
        n_checks++;
        if (instr_d !== NOP || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_noack: got instr=%h addr=%h, required %h 0", instr_d, imem_addr, NOP);
        end
        $display("test_reset done");
    endtask

    task automatic test_zero_wait();
        lat = 0; mem_en = 1;
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (imem_addr !== 32'(i * 4)) begin
                n_fail++; $display("FAIL zw_addr: got %h, required %h", imem_addr, 32'(i * 4));
            end
            step();
            n_checks++;
            if (instr_d !== mem_word(32'(i * 4))) begin
                n_fail++; $display("FAIL zw_instr: got %h, required %h", instr_d, mem_word(32'(i * 4)));
            end
        end
        mem_en = 0;
        n_checks++;
        if (pc_d !== 32'h8 || pc_plus4_d !== 32'hC) begin
            n_fail++; $display("FAIL zw_pc: got %h %h, required 8 c", pc_d, pc_plus4_d);
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL zw_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("test_zero_wait done");
    endtask

    task automatic test_latency();
        logic [31:0] exp_addr;
        lat = 2; mem_en = 1;
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        for (int i = 1; i <= 6; i++) begin
            step();
            exp_addr = (i < 3) ? 32'h0 : ((i < 6) ? 32'h4 : 32'h8);
            n_checks++;
            if (imem_addr !== exp_addr) begin
                n_fail++; $display("FAIL lat_addr: edge %0d got %h, required %h", i, imem_addr, exp_addr);
            end
            if (i != 3 && i != 6) begin
                n_checks++;
                if (instr_d !== NOP || pc_d !== 32'h0 || pc_plus4_d !== 32'h0) begin
                    n_fail++; $display("FAIL lat_bubble: edge %0d got %h %h, required %h 0", i, instr_d, pc_d, NOP);
                end
            end
        end
        mem_en = 0;
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL lat_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("test_latency done");
    endtask

    task automatic test_stall();
        lat = 0; mem_en = 1;
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        step();
        step();
        stall_d = 1;
        n_checks++;
        if (imem_addr !== 32'h8 || imem_ack !== 1'b1) begin
            n_fail++; $display("FAIL st_addr: got %h ack=%b, required 8 1", imem_addr, imem_ack);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (imem_req !== 1'b0 || instr_d !== mem_word(32'h4) || pc_d !== 32'h4) begin
                n_fail++; $display("FAIL st_hold: got req=%b instr=%h pc=%h, required 0 %h 4", imem_req, instr_d, pc_d, mem_word(32'h4));
            end
        end
        stall_d = 0; mem_en = 0;
        step();
        n_checks++;
        if (instr_d !== mem_word(32'h8) || pc_d !== 32'h8 || pc_plus4_d !== 32'hC) begin
            n_fail++; $display("FAIL st_release: got %h %h %h, required %h 8 c", instr_d, pc_d, pc_plus4_d, mem_word(32'h8));
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            n_fail++; $display("FAIL st_next: got req=%b addr=%h, required 1 c", imem_req, imem_addr);
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL st_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("test_stall done");
    endtask

    task automatic test_redirect_kill();
        lat = 0; mem_en = 1;
        do_reset();
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        repeat (4) step();
        n_checks++;
        if (imem_addr !== 32'h10) begin
            n_fail++; $display("FAIL rk_pre: got %h, required 10", imem_addr);
        end
        lat = 3; pc_src_e = 1; pc_target_e = 32'h100; flush_d = 1;
        step();
        pc_src_e = 0; flush_d = 0; pc_target_e = '0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (instr_d !== NOP || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
                n_fail++; $display("FAIL rk_kill: got instr=%h addr=%h req=%b, required %h 10 1", instr_d, imem_addr, imem_req, NOP);
            end
            step();
        end
        n_checks++;
        if (instr_d !== NOP || imem_addr !== 32'h100) begin
            n_fail++; $display("FAIL rk_discard: got instr=%h addr=%h, required %h 100", instr_d, imem_addr, NOP);
        end
        lat = 0;
        exp_q.push_back(32'h100);
        step();
        mem_en = 0;
        n_checks++;
        if (instr_d !== mem_word(32'h100) || pc_d !== 32'h100) begin
            n_fail++; $display("FAIL rk_target: got %h %h, required %h 100", instr_d, pc_d, mem_word(32'h100));
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rk_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("test_redirect_kill done");
    endtask

    task automatic test_redirect_drop();
        lat = 0; mem_en = 1;
        do_reset();
        exp_q.push_back(32'h0);
        step();
        pc_src_e = 1; pc_target_e = 32'h203; flush_d = 1;
        step();
        pc_src_e = 0; flush_d = 0;
        n_checks++;
        if (instr_d !== NOP || imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL rd_ack: got instr=%h addr=%h, required %h 200", instr_d, imem_addr, NOP);
        end
        exp_q.push_back(32'h200);
        step();
        n_checks++;
        if (instr_d !== mem_word(32'h200) || pc_d !== 32'h200 || pc_plus4_d !== 32'h204) begin
            n_fail++; $display("FAIL rd_target: got %h %h %h, required %h 200 204", instr_d, pc_d, pc_plus4_d, mem_word(32'h200));
        end
        stall_d = 1;
        step();
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL rd_hold: got req=%b, required 0", imem_req);
        end
        pc_src_e = 1; pc_target_e = 32'h300; flush_d = 1;
        step();
        pc_src_e = 0; flush_d = 0; stall_d = 0;
        n_checks++;
        if (instr_d !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            n_fail++; $display("FAIL rd_holdredir: got instr=%h req=%b addr=%h, required %h 1 300", instr_d, imem_req, imem_addr, NOP);
        end
        exp_q.push_back(32'h300);
        step();
        mem_en = 0;
        n_checks++;
        if (instr_d !== mem_word(32'h300) || pc_d !== 32'h300) begin
            n_fail++; $display("FAIL rd_after: got %h %h, required %h 300", instr_d, pc_d, mem_word(32'h300));
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rd_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("test_redirect_drop done");
    endtask

    task automatic test_wrap();
        lat = 0; mem_en = 1;
        do_reset();
        exp_q.push_back(32'h0);
        step();
        pc_src_e = 1; pc_target_e = 32'hFFFF_FFFE; flush_d = 1;
        step();
        pc_src_e = 0; flush_d = 0;
        n_checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wr_addr: got %h, required fffffffc", imem_addr);
        end
        exp_q.push_back(32'hFFFF_FFFC);
        step();
        mem_en = 0;
        n_checks++;
        if (pc_d !== 32'hFFFF_FFFC || pc_plus4_d !== 32'h0 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL wr_wrap: got pc=%h pc4=%h addr=%h, required fffffffc 0 0", pc_d, pc_plus4_d, imem_addr);
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL wr_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("test_wrap done");
    endtask

    task automatic test_async_reset();
        lat = 0; mem_en = 1;
        do_reset();
        exp_q.push_back(32'h0);
        step();
        lat = 5; stall_d = 1;
        step();
        n_checks++;
        if (instr_d !== mem_word(32'h0) || pc_plus4_d !== 32'h4 || imem_addr !== 32'h4) begin
            n_fail++; $display("FAIL ar_pre: got %h %h %h, required %h 4 4", instr_d, pc_plus4_d, imem_addr, mem_word(32'h0));
        end
        #2;
        srst = 1;
        #1;
        n_checks++;
        if (instr_d !== NOP || pc_d !== 32'h0 || pc_plus4_d !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL ar_async: got %h %h %h req=%b addr=%h, required %h 0 0 0 0",
                               instr_d, pc_d, pc_plus4_d, imem_req, imem_addr, NOP);
        end
        stall_d = 0; lat = 0;
        step();
        srst = 0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL ar_restart: got req=%b addr=%h, required 1 0", imem_req, imem_addr);
        end
        exp_q.push_back(32'h0);
        step();
        mem_en = 0;
        n_checks++;
        if (instr_d !== mem_word(32'h0) || pc_d !== 32'h0) begin
            n_fail++; $display("FAIL ar_first: got %h %h, required %h 0", instr_d, pc_d, mem_word(32'h0));
        end
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL ar_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall();
        test_redirect_kill();
        test_redirect_drop();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
